ramb4_s1_port_arbiter: RTL and testbench
========================================

Name: ramb4_s1_port_arbiter

Overview:
- Shares one port of a 4096x1 dual-port block RAM between two requesters, using round-robin arbitration.
- Provides a built-in clear sequencer that writes FILL_VAL to every address in turn.
- Drives the RAM port's EN/WE/ADDR/DI from registers and returns read data tagged with the requester ID.
- Sits between client logic and one port (A or B) of the RAM primitive; the other port stays free for unrelated use.

Parameters:
- ADDR_W, 12, address width; the RAM depth is 2**ADDR_W.
- FILL_VAL, 1'b0, data value written at every address by the clear sweep.

Ports:
- CLK  in  1  single clock; all logic samples on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ0  in  1  requester 0 access request.
- WE0  in  1  requester 0 write enable (1 = write, 0 = read).
- ADDR0  in  ADDR_W  requester 0 address.
- DI0  in  1  requester 0 write data.
- GNT0  out  1  requester 0 grant (combinational, same cycle as acceptance).
- REQ1, WE1, ADDR1, DI1, GNT1: same as requester 0, for requester 1.
- CLR  in  1  single-cycle request to start a clear sweep.
- BUSY  out  1  high while the clear sweep is running.
- RAM_EN  out  1  RAM port enable, registered.
- RAM_WE  out  1  RAM port write enable, registered.
- RAM_ADDR  out  ADDR_W  RAM port address, registered.
- RAM_DI  out  1  RAM port write data, registered.
- RAM_DO  in  1  RAM port read data (the RAM has a 1-cycle synchronous read).
- RD_VLD  out  1  read data valid.
- RD_ID  out  1  requester ID that owns the current RD_DATA.
- RD_DATA  out  1  read data; equals RAM_DO when RD_VLD=1, otherwise 0.

Behaviour:
Reset:
- All outputs are 0, state = IDLE, clear counter = 0, last-grant pointer LAST = 1 (so requester 0 wins the first tie).
- The read pipeline is flushed.

States:
- IDLE -> CLEAR when CLR=1 is sampled.
- CLEAR -> IDLE after the write to address 2**ADDR_W-1 has been issued.
- CLR while in CLEAR is ignored.

Arbitration (IDLE only):
- GNTx = 1 when REQx=1 and x wins the arbitration; at most one grant per cycle.
- If only one requester asserts REQ, it wins.
- If both assert REQ, the requester that is not LAST wins.
- LAST updates to the winner on the clock edge.
- A requester holds REQ/WE/ADDR/DI stable until it sees GNT; the access is accepted on the edge that ends the GNT cycle.
- GNT0 = GNT1 = 0 while in CLEAR, and in the IDLE cycle where CLR=1 (CLR has priority over requests).

Issue:
- On the accept edge: RAM_EN=1, RAM_WE=WEx, RAM_ADDR=ADDRx, RAM_DI=DIx.
- In any cycle with no accept and no sweep step, RAM_EN=RAM_WE=0; RAM_ADDR and RAM_DI hold their values.

Read latency:
- Grant in cycle N -> RAM samples the access at the end of cycle N+1 -> RD_VLD=1 with RD_ID=x and RD_DATA=RAM_DO in cycle N+2.
- Latency is exactly 2 cycles from GNT to RD_VLD, with full throughput of 1 read per cycle.
- Writes produce no RD_VLD.
- Reads already in flight when CLEAR is entered complete normally.

Clear sweep:
- In the first CLEAR cycle, BUSY=1 (registered, it rises on the edge that samples CLR).
- Each CLEAR cycle issues RAM_EN=1, RAM_WE=1, RAM_DI=FILL_VAL, RAM_ADDR=counter, then increments the counter.
- Exactly 2**ADDR_W consecutive writes are issued, to addresses 0..2**ADDR_W-1 in ascending order.
- After address 2**ADDR_W-1 is issued: the counter wraps to 0, the state returns to IDLE, and BUSY drops on the same edge.
- Grants are available again in the cycle after BUSY falls.

Reset mid-operation:
- RST during CLEAR or with reads in flight aborts immediately: BUSY=0, RD_VLD=0, counter=0, no further RAM writes.

Test Plan:
- Release reset with all inputs 0 -> all outputs 0 for 5 cycles; RAM_EN never asserts.
- REQ0=1, WE0=0, ADDR0=12'h0A5 held; RAM preloaded with 1 at 0x0A5 -> GNT0 in cycle N; RAM_EN=1, RAM_ADDR=0x0A5 in N+1; RD_VLD=1, RD_ID=0, RD_DATA=1 in N+2.
- REQ0 and REQ1 both held high, reads, for 6 cycles -> grants alternate 0,1,0,1,0,1; RD_ID follows the same sequence 2 cycles later, with RD_VLD high continuously.
- R1 writes DI1=1 to 12'hFFF, then R0 reads 12'hFFF -> RD_ID=0, RD_DATA=1; no RD_VLD for the write.
- Pulse CLR with FILL_VAL=0 while REQ0 is held -> BUSY high for exactly 4096 cycles; RAM_ADDR steps 0..4095 with RAM_WE=1; GNT0=0 throughout; GNT0 asserts in the first cycle after BUSY falls; a read of 12'hFFF then returns 0.
- Assert RST at sweep address 100 -> BUSY=0 and RAM_EN=0 immediately; after release, a new CLR restarts the sweep at address 0.

Source files
------------

// File: rtl/ramb4_s1_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ramb4_s1_port_arbiter_if
//   Bundles every signal of the 4096x1 RAM port arbiter except clk/rst.
//
//   Client side : req0/we0/addr0/di0 -> gnt0, same set for requester 1,
//                 clr -> busy, read return rd_vld/rd_id/rd_data.
//   RAM side    : ram_en/ram_we/ram_addr/ram_di -> ram_do.
//
//   Modports
//     slave  : the arbiter itself
//     master : client logic (both requesters plus the clear requester)
//     ram    : the RAM primitive port being shared
// ---------------------------------------------------------------------------
interface ramb4_s1_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  // requester 0
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic              di0;
  logic              gnt0;
  // requester 1
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic              di1;
  logic              gnt1;
  // clear sequencer
  logic              clr;
  logic              busy;
  // RAM port
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_di;
  logic              ram_do;
  // read return
  logic              rd_vld;
  logic              rd_id;
  logic              rd_data;

  modport slave (
    input  req0, we0, addr0, di0,
    input  req1, we1, addr1, di1,
    input  clr,
    input  ram_do,
    output gnt0, gnt1, busy,
    output ram_en, ram_we, ram_addr, ram_di,
    output rd_vld, rd_id, rd_data
  );

  modport master (
    output req0, we0, addr0, di0,
    output req1, we1, addr1, di1,
    output clr,
    input  gnt0, gnt1, busy,
    input  rd_vld, rd_id, rd_data
  );

  modport ram (
    input  ram_en, ram_we, ram_addr, ram_di,
    output ram_do
  );
endinterface

// File: rtl/ramb4_s1_port_arbiter.sv
// ---------------------------------------------------------------------------
// ramb4_s1_port_arbiter
//   Shares one port of a 2**ADDR_W x 1 dual-port block RAM between two
//   requesters with round-robin arbitration, and provides a clear sweep that
//   writes FILL_VAL to every address in ascending order.
//
//   Ports
//     clk  : single clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : slave view of ramb4_s1_port_arbiter_if
//              requests  req/we/addr/di(0,1) -> gnt0/gnt1 (combinational)
//              clr (single-cycle pulse)      -> busy (registered)
//              ram_en/we/addr/di registered toward the RAM, ram_do back
//              rd_vld/rd_id/rd_data: read return, 2 cycles after the grant
// ---------------------------------------------------------------------------
module ramb4_s1_port_arbiter #(
  parameter int   ADDR_W   = 12,
  parameter logic FILL_VAL = 1'b0
) (
  input logic                     clk,
  input logic                     rst,
  ramb4_s1_port_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state_q,    state_d;
  logic [ADDR_W-1:0] cnt_q,      cnt_d;
  logic              last_q,     last_d;
  logic              busy_q,     busy_d;
  logic              ram_en_q,   ram_en_d;
  logic              ram_we_q,   ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_di_q,   ram_di_d;
  // Read pipeline: pend = access presented to the RAM this cycle,
  // rd = RAM data available this cycle.
  logic              pend_vld_q, pend_vld_d;
  logic              pend_id_q,  pend_id_d;
  logic              rd_vld_q,   rd_vld_d;
  logic              rd_id_q,    rd_id_d;

  logic arb_en;
  logic gnt0;
  logic gnt1;

  // A CLR sample takes priority over any request in the same cycle.
  assign arb_en = (state_q == ST_IDLE) && !bus.clr;

  // On a tie the requester that did not win last time takes the port.
  assign gnt0 = arb_en && bus.req0 && (!bus.req1 ||  last_q);
  assign gnt1 = arb_en && bus.req1 && (!bus.req0 || !last_q);

  always_comb begin
    // NOTE: every signal gets a default before any branch so the
    // combinational block can never infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    busy_d     = busy_q;
    ram_en_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_di_d   = ram_di_q;
    pend_vld_d = 1'b0;
    pend_id_d  = 1'b0;
    rd_vld_d   = pend_vld_q;
    rd_id_d    = pend_id_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.clr) begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
        end else if (gnt0 || gnt1) begin
          ram_en_d   = 1'b1;
          ram_we_d   = gnt1 ? bus.we1   : bus.we0;
          ram_addr_d = gnt1 ? bus.addr1 : bus.addr0;
          ram_di_d   = gnt1 ? bus.di1   : bus.di0;
          last_d     = gnt1;
          // Only reads come back; writes leave the pipeline empty.
          pend_vld_d = !ram_we_d;
          pend_id_d  = gnt1 && !ram_we_d;
        end
      end

      ST_CLEAR: begin
        ram_en_d   = 1'b1;
        ram_we_d   = 1'b1;
        ram_addr_d = cnt_q;
        ram_di_d   = FILL_VAL;
        // Natural wrap returns the counter to 0 after the last address.
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only,
  // so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      busy_q     <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_di_q   <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_id_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_id_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_di_q   <= ram_di_d;
      pend_vld_q <= pend_vld_d;
      pend_id_q  <= pend_id_d;
      rd_vld_q   <= rd_vld_d;
      rd_id_q    <= rd_id_d;
    end
  end

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.busy     = busy_q;
  assign bus.ram_en   = ram_en_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_di   = ram_di_q;
  assign bus.rd_vld   = rd_vld_q;
  assign bus.rd_id    = rd_id_q;
  // RAM_DO is only meaningful in the cycle the read pipeline says so.
  assign bus.rd_data  = rd_vld_q & bus.ram_do;

endmodule

// File: tb/tb_ramb4_s1_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ramb4_s1_port_arbiter
//   Directed bench for ramb4_s1_port_arbiter: a per-cycle vector table for
//   reads, round-robin and write/read-back, then hand-written sequences for
//   the clear sweep and reset in the middle of a sweep. A 4096x1 RAM with a
//   1-cycle synchronous read sits on the RAM side.
// ---------------------------------------------------------------------------
module tb_ramb4_s1_port_arbiter;

  localparam int   ADDR_W = 12;
  localparam int   DEPTH  = 1 << ADDR_W;
  localparam logic L      = 1'b0;
  localparam logic H      = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ramb4_s1_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  ramb4_s1_port_arbiter #(.ADDR_W(ADDR_W), .FILL_VAL(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: synchronous read of the addressed bit when enabled.
  logic mem [DEPTH];
  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = 1'b0;
    mem[12'h0A5] = 1'b1;
    bus.ram_do = 1'b0;
  end
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
      bus.ram_do <= mem[bus.ram_addr];
    end
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic              r0, w0; logic [ADDR_W-1:0] a0; logic d0;
    logic              r1, w1; logic [ADDR_W-1:0] a1; logic d1;
    logic              clr;
    logic              g0, g1, en, we; logic [ADDR_W-1:0] addr; logic di;
    logic              vld, id, data, busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input vec_t v);
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    bus.req0 = L; bus.we0 = L; bus.addr0 = '0; bus.di0 = L;
    bus.req1 = L; bus.we1 = L; bus.addr1 = '0; bus.di1 = L;
    bus.clr  = L;
  endtask

  int  n;
  logic found;
  int  addr_err;
  int  gnt_err;

  initial begin
    drive_idle();

    // Field order: r0,w0,a0,d0, r1,w1,a1,d1, clr, g0,g1,en,we,addr,di, vld,id,data,busy
    for (int i = 0; i < 5; i++)
      add(vec_t'{L,L,12'h000,L, L,L,12'h000,L, L, L,L,L,L,12'h000,L, L,L,L,L});
    // single read of 0x0A5 by requester 0
    add(vec_t'{H,L,12'h0A5,L, L,L,12'h000,L, L, H,L,L,L,12'h000,L, L,L,L,L});
    add(vec_t'{L,L,12'h000,L, L,L,12'h000,L, L, L,L,H,L,12'h0A5,L, L,L,L,L});
    add(vec_t'{L,L,12'h000,L, L,L,12'h000,L, L, L,L,L,L,12'h0A5,L, H,L,H,L});
    // single read of 0x010 by requester 1 (sets LAST = 1)
    add(vec_t'{L,L,12'h000,L, H,L,12'h010,L, L, L,H,L,L,12'h0A5,L, L,L,L,L});
    add(vec_t'{L,L,12'h000,L, L,L,12'h000,L, L, L,L,H,L,12'h010,L, L,L,L,L});
    add(vec_t'{L,L,12'h000,L, L,L,12'h000,L, L, L,L,L,L,12'h010,L, H,H,L,L});
    // both requesting reads for 6 cycles: 0,1,0,1,0,1
    add(vec_t'{H,L,12'h0A5,L, H,L,12'h010,L, L, H,L,L,L,12'h010,L, L,L,L,L});
    add(vec_t'{H,L,12'h0A5,L, H,L,12'h010,L, L, L,H,H,L,12'h0A5,L, L,L,L,L});
    for (int i = 0; i < 2; i++) begin
      add(vec_t'{H,L,12'h0A5,L, H,L,12'h010,L, L, H,L,H,L,12'h010,L, H,L,H,L});
      add(vec_t'{H,L,12'h0A5,L, H,L,12'h010,L, L, L,H,H,L,12'h0A5,L, H,H,L,L});
    end
    add(vec_t'{L,L,12'h000,L, L,L,12'h000,L, L, L,L,H,L,12'h010,L, H,L,H,L});
    add(vec_t'{L,L,12'h000,L, L,L,12'h000,L, L, L,L,L,L,12'h010,L, H,H,L,L});
    add(vec_t'{L,L,12'h000,L, L,L,12'h000,L, L, L,L,L,L,12'h010,L, L,L,L,L});
    // R1 writes 1 to 0xFFF, then R0 reads it back
    add(vec_t'{L,L,12'h000,L, H,H,12'hFFF,H, L, L,H,L,L,12'h010,L, L,L,L,L});
    add(vec_t'{H,L,12'hFFF,L, L,L,12'h000,L, L, H,L,H,H,12'hFFF,H, L,L,L,L});
    add(vec_t'{L,L,12'h000,L, L,L,12'h000,L, L, L,L,H,L,12'hFFF,L, L,L,L,L});
    add(vec_t'{L,L,12'h000,L, L,L,12'h000,L, L, L,L,L,L,12'hFFF,L, H,L,H,L});
    add(vec_t'{L,L,12'h000,L, L,L,12'h000,L, L, L,L,L,L,12'hFFF,L, L,L,L,L});
    // CLR together with a held request: CLR wins, no grant
    add(vec_t'{H,L,12'hFFF,L, L,L,12'h000,L, H, L,L,L,L,12'hFFF,L, L,L,L,L});

    // reset, release just after an edge
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.req0 = vecs[i].r0; bus.we0 = vecs[i].w0; bus.addr0 = vecs[i].a0; bus.di0 = vecs[i].d0;
      bus.req1 = vecs[i].r1; bus.we1 = vecs[i].w1; bus.addr1 = vecs[i].a1; bus.di1 = vecs[i].d1;
      bus.clr  = vecs[i].clr;
      @(negedge clk);
      check($sformatf("row%0d_gnt0", i),     bus.gnt0,     vecs[i].g0);
      check($sformatf("row%0d_gnt1", i),     bus.gnt1,     vecs[i].g1);
      check($sformatf("row%0d_ram_en", i),   bus.ram_en,   vecs[i].en);
      check($sformatf("row%0d_ram_we", i),   bus.ram_we,   vecs[i].we);
      check($sformatf("row%0d_ram_addr", i), bus.ram_addr, vecs[i].addr);
      check($sformatf("row%0d_ram_di", i),   bus.ram_di,   vecs[i].di);
      check($sformatf("row%0d_rd_vld", i),   bus.rd_vld,   vecs[i].vld);
      if (vecs[i].vld)
        check($sformatf("row%0d_rd_id", i),  bus.rd_id,    vecs[i].id);
      check($sformatf("row%0d_rd_data", i),  bus.rd_data,  vecs[i].data);
      check($sformatf("row%0d_busy", i),     bus.busy,     vecs[i].busy);
      @(posedge clk);
      #1;
    end

    // ---- clear sweep with REQ0 held (read of 0xFFF), CLR re-pulsed mid-sweep
    bus.clr = L;
    @(negedge clk);
    n = 0; addr_err = 0; gnt_err = 0;
    while (bus.busy && n < 5000) begin
      if (bus.gnt0 || bus.gnt1) gnt_err++;
      if (n == 0) begin
        if (bus.ram_en) addr_err++;
      end else if (!bus.ram_en || !bus.ram_we || bus.ram_di ||
                   bus.ram_addr != ADDR_W'(n - 1)) begin
        addr_err++;
      end
      @(posedge clk);
      #1 bus.clr = (n == 9);
      n++;
      @(negedge clk);
    end
    check("sweep_busy_cycles", n, DEPTH);
    check("sweep_addr_errors", addr_err, 0);
    check("sweep_gnt_errors", gnt_err, 0);
    check("post_sweep_busy", bus.busy, 0);
    check("post_sweep_gnt0", bus.gnt0, 1);
    check("post_sweep_last_en", bus.ram_en, 1);
    check("post_sweep_last_addr", bus.ram_addr, 12'hFFF);
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
    check("post_sweep_read_en", bus.ram_en, 1);
    check("post_sweep_read_we", bus.ram_we, 0);
    @(posedge clk);
    @(negedge clk);
    check("post_sweep_rd_vld", bus.rd_vld, 1);
    check("post_sweep_rd_id", bus.rd_id, 0);
    check("post_sweep_rd_data", bus.rd_data, 0);

    // ---- reset in the middle of a sweep, at address 100
    @(posedge clk);
    #1 bus.clr = H;
    @(posedge clk);
    #1 bus.clr = L;
    found = 1'b0;
    n = 0;
    while (!found && n < 300) begin
      @(negedge clk);
      found = bus.ram_en && (bus.ram_addr == 12'd100);
      n++;
    end
    check("sweep_reach_100", found, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_ram_en", bus.ram_en, 0);
    check("rst_mid_rd_vld", bus.rd_vld, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_ram_en", bus.ram_en, 0);
    check("rst_hold_ram_addr", bus.ram_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.clr = H;
    @(negedge clk);
    check("restart_clr_cycle_busy", bus.busy, 0);
    @(posedge clk);
    #1 bus.clr = L;
    @(negedge clk);
    check("restart_busy", bus.busy, 1);
    check("restart_first_en", bus.ram_en, 0);
    @(posedge clk);
    @(negedge clk);
    check("restart_addr0_en", bus.ram_en, 1);
    check("restart_addr0_we", bus.ram_we, 1);
    check("restart_addr0", bus.ram_addr, 0);
    @(posedge clk);
    @(negedge clk);
    check("restart_addr1", bus.ram_addr, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
